// File: rtl/csync_decoder.sv
// Composite-sync receiver: measures active-low sync pulses in dot units, classifies
// them (glitch/EQ/HS/SERR) and recovers hsync, vsync, field parity and line lock.
module csync_decoder #(
  parameter int GLITCH_MAX = 4,
  parameter int EQ_MAX     = 28,
  parameter int HS_MAX     = 100,
  parameter int SERR_MAX   = 400,
  parameter int PER_TOL    = 8,
  parameter int LOCK_LINES = 4,
  parameter int VPULSE_MAX = 12
) (
  input  logic       clk_dot4x,
  input  logic       rst_n,
  input  logic [1:0] chip,
  input  logic       csync_n,
  output logic       hs_pulse,
  output logic       vs_start,
  output logic       vsync,
  output logic       field,
  output logic       locked,
  output logic [1:0] pulse_class
);

  localparam logic [1:0] CHIP6567R8   = 2'd0;
  localparam logic [1:0] CHIP6567R56A = 2'd1;
  localparam logic [1:0] CHIP6569R1   = 2'd2;
  localparam logic [1:0] CHIP6569R3   = 2'd3;

  localparam logic [1:0] CLS_GLITCH = 2'd0;
  localparam logic [1:0] CLS_EQ     = 2'd1;
  localparam logic [1:0] CLS_HS     = 2'd2;
  localparam logic [1:0] CLS_SERR   = 2'd3;

  localparam int GW = $clog2(LOCK_LINES + 1);
  localparam int VW = $clog2(VPULSE_MAX + 1);

  localparam logic [9:0]  GLITCH_W = 10'(GLITCH_MAX);
  localparam logic [9:0]  EQ_W     = 10'(EQ_MAX);
  localparam logic [9:0]  HS_W     = 10'(HS_MAX);
  localparam logic [9:0]  SERR_W   = 10'(SERR_MAX);
  localparam logic [10:0] TOL      = 11'(PER_TOL);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_LINES - 1);
  localparam logic [VW-1:0] VCNT_MAX  = VW'(VPULSE_MAX);

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LINE,
    ST_PRE_EQ,
    ST_VSYNC,
    ST_POST_EQ
  } state_t;

  state_t         state_reg, state_next;
  logic           sync1_reg, sync2_reg, sync3_reg;
  logic [1:0]     presc_reg;
  logic [9:0]     width_reg, width_inc;
  logic [10:0]    period_reg, period_inc, tent_reg;
  logic [GW-1:0]  good_reg, good_next;
  logic           err_reg, err_next;
  logic [VW-1:0]  vcnt_reg, vcnt_next;
  logic           hs_reg, hs_next, vs_reg, vs_next;
  logic           vsync_reg, vsync_next, field_reg, field_next;
  logic           locked_reg, locked_next;
  logic [1:0]     class_reg, class_next;

  logic           fall, rise, tick, commit, timeout, abandon;
  logic [1:0]     cls;
  logic [10:0]    line_len, half_len, dbl_len;
  logic           ok_line, ok_half;

  function automatic logic near(input logic [10:0] a, input logic [10:0] b);
    logic [10:0] d;
    d = (a >= b) ? (a - b) : (b - a);
    return d <= TOL;
  endfunction

  assign fall = sync3_reg & ~sync2_reg;
  assign rise = ~sync3_reg & sync2_reg;
  assign tick = (presc_reg == 2'd3);

  // Counters include this cycle's tick so a rise sees the full low width.
  always_comb begin
    width_inc  = width_reg;
    period_inc = period_reg;
    if (tick && width_reg != '1)
      width_inc = width_reg + 10'd1;
    if (tick && period_reg != '1)
      period_inc = period_reg + 11'd1;
  end

  always_comb begin
    case (chip)
      CHIP6567R8:   line_len = 11'd520;
      CHIP6567R56A: line_len = 11'd512;
      CHIP6569R1:   line_len = 11'd504;
      CHIP6569R3:   line_len = 11'd504;
    endcase
  end

  assign half_len = line_len >> 1;
  assign dbl_len  = line_len << 1;
  assign ok_line  = near(tent_reg, line_len);
  assign ok_half  = near(tent_reg, half_len);

  always_comb begin
    cls = CLS_SERR;
    if (width_inc < GLITCH_W)
      cls = CLS_GLITCH;
    else if (width_inc <= EQ_W)
      cls = CLS_EQ;
    else if (width_inc <= HS_W)
      cls = CLS_HS;
  end

  assign commit = rise && (cls != CLS_GLITCH);

  // The width counter is stale on the falling-edge cycle itself, hence the sync3 term.
  assign timeout = (period_reg >= dbl_len) ||
                   (!sync2_reg && !sync3_reg && (width_reg > SERR_W)) ||
                   (rise && (width_inc > SERR_W));

  always_comb begin
    state_next  = state_reg;
    good_next   = good_reg;
    err_next    = err_reg;
    vcnt_next   = vcnt_reg;
    locked_next = locked_reg;
    vsync_next  = vsync_reg;
    field_next  = field_reg;
    class_next  = class_reg;
    hs_next     = 1'b0;
    vs_next     = 1'b0;
    abandon     = 1'b0;

    if (rise)
      class_next = cls;

    if (timeout) begin
      abandon = 1'b1;
    end else if (commit) begin
      case (state_reg)
        ST_HUNT: begin
          if (cls == CLS_HS && ok_line) begin
            if (good_reg == GOOD_LAST) begin
              state_next  = ST_LINE;
              locked_next = 1'b1;
              good_next   = '0;
              err_next    = 1'b0;
            end else begin
              good_next = good_reg + 1'b1;
            end
          end else begin
            good_next = '0;
          end
        end
        ST_LINE: begin
          case (cls)
            CLS_HS: begin
              if (!ok_line && err_reg) begin
                abandon = 1'b1;
              end else begin
                hs_next  = 1'b1;
                err_next = !ok_line;
              end
            end
            CLS_EQ: begin
              state_next = ST_PRE_EQ;
              field_next = ok_half;
              vcnt_next  = VW'(1);
              err_next   = 1'b0;
            end
            default: begin
              state_next = ST_VSYNC;
              vs_next    = 1'b1;
              vsync_next = 1'b1;
              field_next = ok_half;
              vcnt_next  = VW'(1);
              err_next   = 1'b0;
            end
          endcase
        end
        ST_PRE_EQ: begin
          case (cls)
            CLS_EQ: begin
              if (vcnt_reg == VCNT_MAX) abandon = 1'b1;
              else vcnt_next = vcnt_reg + 1'b1;
            end
            CLS_SERR: begin
              state_next = ST_VSYNC;
              vs_next    = 1'b1;
              vsync_next = 1'b1;
              vcnt_next  = VW'(1);
            end
            default: begin
              state_next = ST_LINE;
              hs_next    = 1'b1;
              vcnt_next  = '0;
            end
          endcase
        end
        ST_VSYNC: begin
          case (cls)
            CLS_SERR: begin
              if (vcnt_reg == VCNT_MAX) abandon = 1'b1;
              else vcnt_next = vcnt_reg + 1'b1;
            end
            CLS_EQ: begin
              state_next = ST_POST_EQ;
              vsync_next = 1'b0;
              vcnt_next  = VW'(1);
            end
            default: begin
              state_next = ST_LINE;
              vsync_next = 1'b0;
              hs_next    = 1'b1;
              vcnt_next  = '0;
            end
          endcase
        end
        ST_POST_EQ: begin
          // A broad pulse here has no defined meaning and is ignored.
          case (cls)
            CLS_EQ: begin
              if (vcnt_reg == VCNT_MAX) abandon = 1'b1;
              else vcnt_next = vcnt_reg + 1'b1;
            end
            CLS_HS: begin
              state_next = ST_LINE;
              hs_next    = 1'b1;
              vcnt_next  = '0;
            end
            default: ;
          endcase
        end
        default: state_next = ST_HUNT;
      endcase
    end

    if (abandon) begin
      state_next  = ST_HUNT;
      locked_next = 1'b0;
      vsync_next  = 1'b0;
      good_next   = '0;
      err_next    = 1'b0;
      vcnt_next   = '0;
      hs_next     = 1'b0;
      vs_next     = 1'b0;
    end
  end

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg  <= 1'b1;
      sync2_reg  <= 1'b1;
      sync3_reg  <= 1'b1;
      presc_reg  <= '0;
      width_reg  <= '0;
      period_reg <= '0;
      tent_reg   <= '0;
    end else begin
      sync1_reg  <= csync_n;
      sync2_reg  <= sync1_reg;
      sync3_reg  <= sync2_reg;
      presc_reg  <= fall ? 2'd0 : presc_reg + 2'd1;
      width_reg  <= fall ? 10'd0 : width_inc;
      // Committing restarts the period from this pulse's own falling edge.
      period_reg <= commit ? {1'b0, width_inc} : period_inc;
      if (fall)
        tent_reg <= period_inc;
    end
  end

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_HUNT;
      good_reg   <= '0;
      err_reg    <= 1'b0;
      vcnt_reg   <= '0;
      hs_reg     <= 1'b0;
      vs_reg     <= 1'b0;
      vsync_reg  <= 1'b0;
      field_reg  <= 1'b0;
      locked_reg <= 1'b0;
      class_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      good_reg   <= good_next;
      err_reg    <= err_next;
      vcnt_reg   <= vcnt_next;
      hs_reg     <= hs_next;
      vs_reg     <= vs_next;
      vsync_reg  <= vsync_next;
      field_reg  <= field_next;
      locked_reg <= locked_next;
      class_reg  <= class_next;
    end
  end

  assign hs_pulse    = hs_reg;
  assign vs_start    = vs_reg;
  assign vsync       = vsync_reg;
  assign field       = field_reg;
  assign locked      = locked_reg;
  assign pulse_class = class_reg;

endmodule

// File: tb/tb_csync_decoder.sv
// Directed bench for csync_decoder: expected per-pulse outputs are queued when a
// pulse is driven and compared when its classification appears.
module tb_csync_decoder;

  logic       clk_dot4x = 1'b0;
  logic       rst_n;
  logic [1:0] chip;
  logic       csync_n;
  logic       hs_pulse, vs_start, vsync, field, locked;
  logic [1:0] pulse_class;

  int checks   = 0;
  int failures = 0;
  int hs_seen  = 0;
  int vs_seen  = 0;

  typedef struct {
    string      tag;
    logic [1:0] cls;
    logic       hs, vs, vsy, fld, lck;
  } exp_t;

  exp_t sb[$];

  csync_decoder dut (
    .clk_dot4x  (clk_dot4x),
    .rst_n      (rst_n),
    .chip       (chip),
    .csync_n    (csync_n),
    .hs_pulse   (hs_pulse),
    .vs_start   (vs_start),
    .vsync      (vsync),
    .field      (field),
    .locked     (locked),
    .pulse_class(pulse_class)
  );

  always #5 clk_dot4x = ~clk_dot4x;

  always @(negedge clk_dot4x) begin
    if (hs_pulse) hs_seen <= hs_seen + 1;
    if (vs_start) vs_seen <= vs_seen + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Low for w dots, next falling edge per dots after this one.
  task automatic pulse(input string tag, input int w, input int per, input logic [1:0] cls,
                       input logic hs, input logic vs, input logic vsy,
                       input logic fld, input logic lck);
    exp_t e;
    e.tag = tag; e.cls = cls; e.hs = hs; e.vs = vs; e.vsy = vsy; e.fld = fld; e.lck = lck;
    sb.push_back(e);
    csync_n = 1'b0;
    repeat (w * 4) @(negedge clk_dot4x);
    csync_n = 1'b1;
    repeat (3) @(posedge clk_dot4x);
    @(negedge clk_dot4x);
    e = sb.pop_front();
    check({e.tag, ".class"},  pulse_class, e.cls);
    check({e.tag, ".hs"},     hs_pulse,    e.hs);
    check({e.tag, ".vs"},     vs_start,    e.vs);
    check({e.tag, ".vsync"},  vsync,       e.vsy);
    check({e.tag, ".field"},  field,       e.fld);
    check({e.tag, ".locked"}, locked,      e.lck);
    repeat (per * 4 - w * 4 - 3) @(negedge clk_dot4x);
  endtask

  initial begin
    rst_n   = 1'b0;
    chip    = 2'd0;
    csync_n = 1'b0;
    repeat (6) @(negedge clk_dot4x);
    check("rst.hs",     hs_pulse,    0);
    check("rst.vs",     vs_start,    0);
    check("rst.vsync",  vsync,       0);
    check("rst.field",  field,       0);
    check("rst.locked", locked,      0);
    check("rst.class",  pulse_class, 0);
    rst_n = 1'b1;

    // Pulse already low at release is timed from release; 300-dot gap is not a line.
    pulse("post_rst", 40, 300, 2'd2, 0, 0, 0, 0, 0);
    pulse("hunt1", 40, 520, 2'd2, 0, 0, 0, 0, 0);
    pulse("hunt2", 40, 520, 2'd2, 0, 0, 0, 0, 0);
    pulse("hunt3", 40, 520, 2'd2, 0, 0, 0, 0, 0);
    pulse("hunt4", 40, 520, 2'd2, 0, 0, 0, 0, 0);
    pulse("lock5", 40, 520, 2'd2, 0, 0, 0, 0, 1);
    pulse("line6", 40, 520, 2'd2, 1, 0, 0, 0, 1);
    pulse("line7", 40, 504, 2'd2, 1, 0, 0, 0, 1);
    chip = 2'd2;
    pulse("pal8", 40, 504, 2'd2, 1, 0, 0, 0, 1);
    pulse("pal9", 40, 252, 2'd2, 1, 0, 0, 0, 1);

    for (int i = 0; i < 6; i++)
      pulse($sformatf("pre_eq%0d", i), 18, 252, 2'd1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++)
      pulse($sformatf("serr%0d", i), 220, 252, 2'd3, 0, (i == 0), 1, 1, 1);
    for (int i = 0; i < 6; i++)
      pulse($sformatf("post_eq%0d", i), 18, 252, 2'd1, 0, 0, 0, 1, 1);
    pulse("ret_line", 40, 504, 2'd2, 1, 0, 0, 1, 1);
    pulse("pal_line", 40, 512, 2'd2, 1, 0, 0, 1, 1);

    chip = 2'd1;
    pulse("ntsc_a", 40, 200, 2'd2, 1, 0, 0, 1, 1);
    pulse("glitch", 3, 312, 2'd0, 0, 0, 0, 1, 1);
    pulse("ntsc_b", 40, 512, 2'd2, 1, 0, 0, 1, 1);

    // Stuck low: lock must survive to W=400 and be gone shortly after.
    csync_n = 1'b0;
    repeat (398 * 4) @(negedge clk_dot4x);
    check("stuck398.locked", locked, 1);
    repeat (12 * 4) @(negedge clk_dot4x);
    check("stuck410.locked", locked, 0);
    check("stuck410.vsync",  vsync,  0);
    check("stuck410.field",  field,  1);
    repeat (590 * 4) @(negedge clk_dot4x);
    csync_n = 1'b1;
    repeat (100 * 4) @(negedge clk_dot4x);

    pulse("relock1", 40, 512, 2'd2, 0, 0, 0, 1, 0);
    pulse("relock2", 40, 512, 2'd2, 0, 0, 0, 1, 0);
    pulse("relock3", 40, 512, 2'd2, 0, 0, 0, 1, 0);
    pulse("relock4", 40, 512, 2'd2, 0, 0, 0, 1, 0);
    pulse("relock5", 40, 512, 2'd2, 0, 0, 0, 1, 1);
    pulse("relock6", 40, 256, 2'd2, 1, 0, 0, 1, 1);

    for (int i = 0; i < 13; i++)
      pulse($sformatf("serr13_%0d", i), 220, 256, 2'd3, 0, (i == 0), (i < 12), 1, (i < 12));

    repeat (4) @(negedge clk_dot4x);
    check("hs_total", 16'(hs_seen), 9);
    check("vs_total", 16'(vs_seen), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
